// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point datapath: operand class codes,
// flag bit positions and format-dependent constants.
package fp_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_e;

  localparam int FLAGS_W        = 4;
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  // Exponent bias for an EXP_W-bit exponent field.
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN {0, all-ones exp, 1, zeros}, returned in a wide
  // vector; callers keep the low 1+EXP_W+MAN_W bits.
  function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
    logic [127:0] v;
    v = ((128'(1) << exp_w) - 128'(1)) << man_w;
    v = v | (128'(1) << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Final stage logic: round-to-nearest-even, renormalise on carry-out,
// overflow/underflow detection, special-case override and packing.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                      sign,
  input  fp_class_e                 cls,
  input  logic signed [EXP_W+1:0]   exp,
  input  logic        [MAN_W:0]     mant,
  input  logic                      guard,
  input  logic                      rnd,
  input  logic                      sticky,
  output logic [EXP_W+MAN_W:0]      result,
  output logic [FLAGS_W-1:0]        flags
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [127:0]            QNAN_FULL = fp_qnan(EXP_W, MAN_W);
  localparam logic signed [EXP_W+1:0] EXP_MAX   = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] EXP_ZERO  = '0;

  logic                    round_up;
  logic                    inexact;
  logic [MAN_W+1:0]        mant_r;
  logic signed [EXP_W+1:0] exp_r;
  logic [MAN_W-1:0]        frac_r;

  // Round, renormalise, then let the class code override the arithmetic.
  always_comb begin
    round_up = guard & (rnd | sticky | mant[0]);
    inexact  = guard | rnd | sticky;
    mant_r   = {1'b0, mant} + (MAN_W+2)'(round_up);
    exp_r    = exp + $signed({{(EXP_W+1){1'b0}}, mant_r[MAN_W+1]});
    frac_r   = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    result   = '0;
    flags    = '0;
    unique case (cls)
      NAN: begin
        result               = QNAN_FULL[W-1:0];
        flags[FLAG_INVALID]  = 1'b1;
      end
      INF:  result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ZERO: result = {sign, {(W-1){1'b0}}};
      default: begin
        if (exp_r >= EXP_MAX) begin
          result                = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags[FLAG_OVERFLOW]  = 1'b1;
          flags[FLAG_INEXACT]   = 1'b1;
        end else if (exp_r <= EXP_ZERO) begin
          // Both operands were normal, so the true product is non-zero.
          result                = {sign, {(W-1){1'b0}}};
          flags[FLAG_UNDERFLOW] = 1'b1;
          flags[FLAG_INEXACT]   = 1'b1;
        end else begin
          result                = {sign, exp_r[EXP_W-1:0], frac_r};
          flags[FLAG_INEXACT]   = inexact;
        end
      end
    endcase
  end

endmodule

// File: rtl/fpmul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready on both
// sides. S1 unpacks and multiplies, S2 normalises, S3 rounds and packs into
// the output register. Every stage may load whenever it is empty or its own
// contents move on in the same cycle, so bubbles never block upstream.
module fpmul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [TAG_W-1:0]         out_tag,
  output logic [FLAGS_W-1:0]       out_flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EXP_W+1:0] BIAS_S  = (EXP_W+2)'(fp_bias(EXP_W));
  localparam logic signed [EXP_W+1:0] EXP_ONE = (EXP_W+2)'(1);

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                         input logic [MAN_W-1:0] f);
    if (e == '0)      return ZERO;   // zero and subnormal both flush to zero
    else if (e == '1) return (f == '0) ? INF : NAN;
    else              return NORM;
  endfunction

  logic en1, en2, en3;
  logic v1, v2, v3;

  // Stage 1 registers
  logic                    sign1;
  fp_class_e               cls1;
  logic signed [EXP_W+1:0] exp1;
  logic [PW-1:0]           prod1;
  logic [TAG_W-1:0]        tag1;

  // Stage 2 registers
  logic                    sign2;
  fp_class_e               cls2;
  logic signed [EXP_W+1:0] exp2;
  logic [MAN_W:0]          mant2;
  logic                    g2, r2, s2;
  logic [TAG_W-1:0]        tag2;

  // Combinational stage outputs
  fp_class_e               ca, cb, cls_s1;
  logic signed [EXP_W+1:0] exp_s1, exp_s2;
  logic [PW-1:0]           prod_s1;
  logic [MAN_W:0]          mant_s2;
  logic                    g_s2, r_s2, s_s2;
  logic [W-1:0]            res_s3;
  logic [FLAGS_W-1:0]      flags_s3;

  assign en3       = !v3 || out_ready;
  assign en2       = !v2 || en3;
  assign en1       = !v1 || en2;
  assign in_ready  = en1;
  assign out_valid = v3;

  // S1: classify operands, resolve specials, add exponents, multiply mantissas.
  always_comb begin
    ca = classify(a[W-2:MAN_W], a[MAN_W-1:0]);
    cb = classify(b[W-2:MAN_W], b[MAN_W-1:0]);
    if (ca == NAN || cb == NAN || (ca == INF && cb == ZERO) || (ca == ZERO && cb == INF))
      cls_s1 = NAN;
    else if (ca == INF || cb == INF)
      cls_s1 = INF;
    else if (ca == ZERO || cb == ZERO)
      cls_s1 = ZERO;
    else
      cls_s1 = NORM;
    exp_s1  = $signed({2'b00, a[W-2:MAN_W]}) + $signed({2'b00, b[W-2:MAN_W]}) - BIAS_S;
    prod_s1 = {{(MAN_W+1){1'b0}}, 1'b1, a[MAN_W-1:0]} *
              {{(MAN_W+1){1'b0}}, 1'b1, b[MAN_W-1:0]};
  end

  // S2: normalise a product in [2,4) down to [1,2) and extract guard/round/sticky.
  always_comb begin
    if (prod1[PW-1]) begin
      mant_s2 = prod1[PW-1:MAN_W+1];
      g_s2    = prod1[MAN_W];
      r_s2    = prod1[MAN_W-1];
      s_s2    = |prod1[MAN_W-2:0];
      exp_s2  = exp1 + EXP_ONE;
    end else begin
      mant_s2 = prod1[PW-2:MAN_W];
      g_s2    = prod1[MAN_W-1];
      r_s2    = prod1[MAN_W-2];
      s_s2    = |prod1[MAN_W-3:0];
      exp_s2  = exp1;
    end
  end

  fp_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .sign   (sign2),
    .cls    (cls2),
    .exp    (exp2),
    .mant   (mant2),
    .guard  (g2),
    .rnd    (r2),
    .sticky (s2),
    .result (res_s3),
    .flags  (flags_s3)
  );

  // Stage 1 register: capture a new operand pair whenever S1 is free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0; sign1 <= 1'b0; cls1 <= ZERO; exp1 <= '0; prod1 <= '0; tag1 <= '0;
    end else if (en1) begin
      v1 <= in_valid;
      if (in_valid) begin
        sign1 <= a[W-1] ^ b[W-1];
        cls1  <= cls_s1;
        exp1  <= exp_s1;
        prod1 <= prod_s1;
        tag1  <= in_tag;
      end
    end
  end

  // Stage 2 register: take the normalised S1 result when S2 is free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2 <= 1'b0; sign2 <= 1'b0; cls2 <= ZERO; exp2 <= '0; mant2 <= '0;
      g2 <= 1'b0; r2 <= 1'b0; s2 <= 1'b0; tag2 <= '0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        sign2 <= sign1;
        cls2  <= cls1;
        exp2  <= exp_s2;
        mant2 <= mant_s2;
        g2    <= g_s2;
        r2    <= r_s2;
        s2    <= s_s2;
        tag2  <= tag1;
      end
    end
  end

  // Output register: holds its contents while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v3 <= 1'b0; result <= '0; out_tag <= '0; out_flags <= '0;
    end else if (en3) begin
      v3 <= v2;
      if (v2) begin
        result    <= res_s3;
        out_tag   <= tag2;
        out_flags <= flags_s3;
      end
    end
  end

endmodule

// File: tb/tb_fpmul_pipe.sv
// Scoreboard bench for fpmul_pipe at default parameters (single precision).
module tb_fpmul_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  out_tag;
  logic [3:0]  out_flags;

  fpmul_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    logic [3:0]  flags;
    int          cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0, n_out = 0, cyc = 0;
  int   bp_mode = 0, pi = 0;
  logic [3:0] pat = 4'b1001;

  logic [31:0] dir_a [9] = '{32'h3f115b57, 32'h3f800000, 32'h00000000, 32'hbf800000,
                             32'h00000001, 32'h7f000000, 32'h7f800000, 32'hffc00001,
                             32'h00800000};
  logic [31:0] dir_b [9] = '{32'h3fab851f, 32'h3f800000, 32'h3fab851f, 32'h40000000,
                             32'h3f800000, 32'h40000000, 32'h00000000, 32'h3f800000,
                             32'h3f000000};
  logic [31:0] dir_r [9] = '{32'h3f42c732, 32'h3f800000, 32'h00000000, 32'hc0000000,
                             32'h00000000, 32'h7f800000, 32'h7fc00000, 32'h7fc00000,
                             32'h00000000};
  logic [3:0]  dir_f [9] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                             4'b0101, 4'b1000, 4'b1000, 4'b0011};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: exact integer product, then RNE by comparing the discarded
  // remainder against one half ulp.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] res, output logic [3:0] fl);
    int ex, ey, e, n, sh;
    logic sg;
    bit zx, zy, ix, iy, nx, ny, inx;
    longint unsigned p, q, rem, half;
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    sg = x[31] ^ y[31];
    zx = (ex == 0); zy = (ey == 0);
    ix = (ex == 255) && (x[22:0] == 0); iy = (ey == 255) && (y[22:0] == 0);
    nx = (ex == 255) && (x[22:0] != 0); ny = (ey == 255) && (y[22:0] != 0);
    if (nx || ny || (ix && zy) || (iy && zx)) begin
      res = 32'h7fc00000; fl = 4'b1000;
    end else if (ix || iy) begin
      res = {sg, 8'hff, 23'h0}; fl = 4'b0000;
    end else if (zx || zy) begin
      res = {sg, 31'h0}; fl = 4'b0000;
    end else begin
      p    = ((64'(1) << 23) | 64'(x[22:0])) * ((64'(1) << 23) | 64'(y[22:0]));
      n    = p[47] ? 47 : 46;
      sh   = n - 23;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'(1) << (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'(1) << 24)) begin q = q >> 1; n++; end
      e = ex + ey - 127 + (n - 46);
      if (e >= 255) begin
        res = {sg, 8'hff, 23'h0}; fl = 4'b0101;
      end else if (e <= 0) begin
        res = {sg, 31'h0}; fl = 4'b0011;
      end else begin
        res = {sg, 8'(e), q[22:0]}; fl = {3'b000, inx};
      end
    end
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0]  e;
    logic [22:0] f;
    int c;
    c = int'($urandom_range(0, 15));
    case (c)
      0:       e = 8'h00;
      1, 2:    e = 8'hff;
      3, 4:    e = 8'($urandom_range(1, 20));
      5, 6:    e = 8'($urandom_range(230, 254));
      7:       e = 8'd127;
      default: e = 8'($urandom_range(1, 254));
    endcase
    f = 23'($urandom);
    if (c == 1) f = '0;
    return {1'($urandom), e, f};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer side: out_ready changes just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = pat[pi]; pi = (pi + 1) % 4; end
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every output transfer, checks hold-stability.
  exp_t        m_e;
  bit          prev_stall = 0;
  logic [31:0] prev_res;
  logic [7:0]  prev_tf;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_result", 64'(result), 64'(prev_res));
        chk("hold_tag_flags", 64'({out_tag, out_flags}), 64'(prev_tf));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_output: got result %h tag %h, required no output", result, out_tag);
        end else begin
          m_e = sb.pop_front();
          chk("result", 64'(result), 64'(m_e.res));
          chk("tag", 64'(out_tag), 64'(m_e.tag));
          chk("flags", 64'(out_flags), 64'(m_e.flags));
          if (m_e.chk_lat) chk("latency", 64'(cyc - m_e.cyc), 64'd3);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = result;
      prev_tf    = {out_tag, out_flags};
    end
  end

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [3:0] t,
                       input logic [31:0] er, input logic [3:0] ef, input bit use_exp);
    exp_t e;
    bit got = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; a = x; b = y; in_tag = t;
    if (use_exp) begin e.res = er; e.flags = ef; end
    else model(x, y, e.res, e.flags);
    e.tag = t;
    e.chk_lat = (bp_mode == 0);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL in_ready_timeout: in_ready 0 for 200 cycles, required 1");
    end else begin
      e.cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic stop_in();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 400; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int snap;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outputs", 64'({out_tag, out_flags, result}), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) drive(dir_a[i], dir_b[i], 4'(i), dir_r[i], dir_f[i], 1);
    stop_in(); drain();

    bp_mode = 1; pi = 0;
    for (int i = 0; i < 8; i++) drive(rnd_op(), rnd_op(), 4'(i), '0, '0, 0);
    stop_in(); drain();

    bp_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) stop_in();
      drive(rnd_op(), rnd_op(), 4'($urandom), '0, '0, 0);
    end
    stop_in(); drain();

    bp_mode = 0;
    for (int i = 0; i < 100; i++) drive(rnd_op(), rnd_op(), 4'($urandom), '0, '0, 0);
    stop_in(); drain();

    // Reset with three operations in flight behind a stalled consumer.
    bp_mode = 3;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 3; i++) drive(rnd_op(), rnd_op(), 4'(8 + i), '0, '0, 0);
    stop_in();
    chk("pre_rst_full", 64'({out_valid, in_ready}), 64'b10);
    rst_n = 1'b0;
    sb.delete();
    snap = n_out;
    @(posedge clk); #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_outputs", 64'({out_tag, out_flags, result}), 64'd0);
    rst_n = 1'b1;
    bp_mode = 0;
    repeat (20) @(posedge clk);
    chk("rst_no_emit", 64'(n_out), 64'(snap));

    for (int i = 0; i < 20; i++) drive(rnd_op(), rnd_op(), 4'($urandom), '0, '0, 0);
    stop_in(); drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fpmul_pipe.md
# fpmul_pipe

Pipelined, parametrised floating-point multiplier; successor to the combinational single-precision `fpmul`. It takes two operands of configurable exponent and mantissa width and produces a correctly rounded product (round-to-nearest-even) with IEEE special-case handling. It uses a 3-stage pipeline with valid/ready handshakes on both sides and an opaque sideband tag. It sits between the operand scheduler and the FP writeback path of the LVG datapath.

## Interface
- `EXP_W`, default 8: exponent width.
- `MAN_W`, default 23: stored fraction width, excluding the hidden bit.
- `TAG_W`, default 4: sideband tag width, carried unchanged with each operation.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block accepts the pair this cycle.
- `a`, `b`  in  1+EXP_W+MAN_W each  operands {sign, exp, frac}.
- `in_tag`  in  TAG_W  sideband.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  1+EXP_W+MAN_W  product.
- `out_tag`  out  TAG_W  tag of that product.
- `out_flags`  out  4  {invalid, overflow, underflow, inexact}.

## Operation
- Transfer rules:
  - Input transfer occurs when `in_valid && in_ready`.
  - Output transfer occurs when `out_valid && out_ready`.
- Stage S1 (unpack/multiply):
  - Classify each operand as zero, subnormal, normal, inf or NaN.
  - Flush subnormal inputs to signed zero.
  - sign = sa ^ sb.
  - exp_sum = ea + eb − BIAS, computed at EXP_W+2 bits signed, where BIAS = 2^(EXP_W−1) − 1.
  - Form the full (MAN_W+1)×(MAN_W+1) mantissa product.
- Stage S2 (normalise):
  - If product bit 2·MAN_W+1 is set, shift right by 1 and increment the exponent.
  - Form guard, round and sticky bits. Sticky is the OR of all remaining lower bits.
- Stage S3 (round/pack):
  - Round to nearest even. If rounding carries out of the mantissa, renormalise and increment the exponent.
  - If exp ≥ 2^EXP_W − 1 after rounding, return ±inf and set overflow and inexact.
  - If exp ≤ 0 after rounding, return signed zero and set underflow. Also set inexact if the product was non-zero.
- Special cases are resolved in S1 and carried as a class code. They override the arithmetic result:
  - Any NaN input, or inf × 0, returns canonical quiet NaN {0, all-ones exp, 1, zeros} and sets invalid.
  - inf × nonzero returns ±inf.
  - Zero × finite returns signed zero.
- Flags are set only as listed above; all other flags are 0.

## Timing
- Latency: exactly 3 cycles from input transfer to `out_valid`, when no stall occurs.
- Throughput: 1 operation per cycle.
- Each stage holds a valid bit. Stage k loads when it is empty or when its own contents advance in the same cycle.
- `in_ready` = !v1 || (S1 advances this cycle). It is combinational from `out_ready` through the stage valids; no combinational path runs from `in_valid` to `in_ready`.
- When `out_ready` = 0 and all stages are full, the pipeline freezes. `result`, `out_tag` and `out_flags` hold stable while `out_valid` is high and not accepted.
- Bubbles collapse: an empty stage never blocks upstream.
- Reset:
  - All valid bits clear, so `out_valid` = 0 and `in_ready` = 1 in the cycle after reset asserts.
  - `result`, `out_tag` and `out_flags` reset to 0.
  - In-flight operations are discarded without output.
- A simultaneous input and output transfer on a full pipeline is legal and keeps it full.

## Structure
- Shared package `fp_pkg` holds:
  - the class-code enum (ZERO, NORM, INF, NAN);
  - the flag bit indices;
  - functions for BIAS and the canonical-NaN constant, parametrised on EXP_W/MAN_W.
- Natural sub-module: `fp_round_pack` (S3 combinational logic: RNE, renormalise, overflow/underflow, pack). Its output is registered by `fpmul_pipe`.
- Pipeline registers and handshake control live in `fpmul_pipe`.

## Test plan
All vectors use default parameters.
- Basic product: 3f115b57 × 3fab851f → 3f42c732, flags 0001; 3f800000 × 3f800000 → 3f800000, flags 0000; both with exactly 3-cycle latency.
- Zero, sign and subnormal flush:
  - 00000000 × 3fab851f → 00000000.
  - bf800000 × 40000000 → c0000000.
  - 00000001 × 3f800000 → 00000000, underflow clear.
- Specials:
  - 7f000000 × 40000000 → 7f800000, overflow and inexact set.
  - 7f800000 × 00000000 → 7fc00000, invalid set.
  - ffc00001 × 3f800000 → 7fc00000.
- Underflow: 00800000 × 3f000000 → 00000000, underflow and inexact set.
- Backpressure and tags:
  - Stream 8 pairs with tags 0–7 while `out_ready` toggles in pattern 1,0,0,1.
  - Required: results arrive in order with matching tags, none lost or duplicated, and outputs stay stable while stalled.
- Reset mid-flight: assert `rst_n` = 0 with 3 operations in flight. Required: `out_valid` is 0 the next cycle, and none of the 3 results is ever emitted.
